exec_step_control: RTL and testbench
====================================

Name: exec_step_control

Overview:
- Execution controller for the single-cycle core. It replaces "debounced button drives the core clock" with a one-cycle clock-enable pulse, CORE_EN, on the system clock.
- Modes: single-step, free-run with programmable rate, PC breakpoints, stall on the core's input-wait instruction, and HALT latching.
- Sits between the board buttons and the core datapath/control unit; every core state element is gated by CORE_EN.

Parameters:
- PC_WIDTH, 32, width of the PC compare bus.
- NUM_BREAK, 2, number of breakpoint comparators (1..8).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level is accepted.
- RUN_DIV, 1, in RUN mode CORE_EN fires once every RUN_DIV cycles (>=1).

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous reset, active-high.
- BTN_STEP  in  1  raw step button, active-high, asynchronous.
- BTN_RUN  in  1  raw run/stop toggle button, active-high, asynchronous.
- BTN_INPUT  in  1  raw input-confirm button, active-high, asynchronous.
- HALT  in  1  core control unit decoded a halt instruction.
- INPUT_WAIT  in  1  current instruction reads switches and needs user confirmation.
- PC  in  PC_WIDTH  current instruction address.
- BREAK_ADDR  in  NUM_BREAK*PC_WIDTH  breakpoint addresses; slice i is [i*PC_WIDTH +: PC_WIDTH].
- BREAK_VALID  in  NUM_BREAK  per-breakpoint enable.
- CORE_EN  out  1  one-cycle core clock-enable pulse.
- STATE  out  3  FSM state: 0 IDLE, 1 STEP, 2 RUN, 3 WAIT_INPUT, 4 HALTED.
- STEP_COUNT  out  32  number of CORE_EN pulses issued; wraps at 2^32.
- BREAK_HIT  out  NUM_BREAK  sticky flag per comparator that stopped the run.

Behaviour:
- Reset (synchronous, active-high):
  - CORE_EN=0, STATE=IDLE, STEP_COUNT=0, BREAK_HIT=0.
  - Divider, skip flag and return-mode bit cleared; debounced levels cleared to 0.
  - Reset wins over every other event in the same cycle.
- Per button conditioning:
  - 2-FF synchronizer, then a counter.
  - The debounced level updates only after DEBOUNCE_CYCLES consecutive cycles of a synchronized value differing from it; any mismatch break restarts the count.
  - A rising edge of the debounced level gives a one-cycle press pulse (step_p, run_p, in_p).
  - Latency from a clean raw edge to the press pulse is DEBOUNCE_CYCLES+3 cycles. Holding a button produces exactly one pulse.
- Issue check, evaluated in any cycle the FSM would assert CORE_EN. Priority order:
  1. HALT=1: go to HALTED, no pulse.
  2. Breakpoint: if BREAK_VALID[i] and PC==slice i for any i, and skip=0, and in RUN: no pulse, set BREAK_HIT[i] for all matching i, go to IDLE.
  3. INPUT_WAIT=1: store return mode (STEP→IDLE, RUN→RUN), go to WAIT_INPUT, no pulse.
  4. Otherwise: CORE_EN=1, STEP_COUNT+1, skip cleared.
- IDLE:
  - step_p goes to STEP; run_p goes to RUN with divider cleared.
  - Both in the same cycle: step_p wins.
  - Leaving IDLE sets skip=1 and clears BREAK_HIT.
- STEP: performs the issue check in the cycle after entry, then returns to IDLE (unless redirected by the check). At most one pulse per step_p.
- RUN:
  - Divider counts 0..RUN_DIV-1; the issue check runs when the divider is 0. RUN_DIV=1 means a check every cycle.
  - run_p goes to IDLE with no pulse that cycle; run_p takes precedence over a same-cycle issue.
  - step_p is ignored.
- WAIT_INPUT:
  - in_p issues one CORE_EN, unconditionally except HALT, then goes to the stored return mode.
  - run_p aborts to IDLE with no pulse.
  - If INPUT_WAIT drops while waiting, the block still waits for in_p.
- HALTED: CORE_EN held 0; all buttons ignored; only RESET exits.
- CORE_EN is registered and never high two consecutive cycles unless RUN with RUN_DIV=1.

Optional Feature:
- Macro: EXEC_BREAKPOINT_EN.
- Defined: comparators and BREAK_HIT logic exist as described.
- Undefined: no comparators are built. BREAK_ADDR, BREAK_VALID and PC are ignored, BREAK_HIT is tied to 0, and RUN never stops on a PC match. Ports remain present.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=3, NUM_BREAK=2):
1. Reset, then BTN_STEP held high 20 cycles → exactly one CORE_EN pulse 8 cycles after the edge; STEP_COUNT=1; STATE returns to 0.
2. BTN_STEP toggling every 2 cycles for 30 cycles, then low → no press pulse, no CORE_EN, STEP_COUNT=0.
3. Run press, wait 30 cycles, run press → CORE_EN every 3rd cycle while STATE=2, at most 10 pulses; STATE=0 afterwards; STEP_COUNT equals the pulse count.
4. BREAK_ADDR slice0=0x10, BREAK_VALID=01, run with PC=0x10 after 2 pulses → pulse suppressed, STATE=0, BREAK_HIT=01; step press with PC=0x10 → one CORE_EN, BREAK_HIT=00.
5. RUN with INPUT_WAIT=1 → STATE=3, no CORE_EN for 50 cycles; BTN_INPUT press → one CORE_EN, STATE=2.
6. HALT=1 during RUN → STATE=4, step/run presses give no CORE_EN; RESET high one cycle → STATE=0, STEP_COUNT=0, CORE_EN=0.

Source files
------------

// File: rtl/exec_step_control.sv
// Execution controller: turns board buttons into a one-cycle core clock-enable (CORE_EN) with step, run, input-wait and halt handling.
// Optional PC breakpoint comparators are built only when EXEC_BREAKPOINT_EN is defined.
module exec_step_control #(
    parameter int PC_WIDTH        = 32,
    parameter int NUM_BREAK       = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 1
) (
    input  logic                           CLOCK,
    input  logic                           RESET,
    input  logic                           BTN_STEP,
    input  logic                           BTN_RUN,
    input  logic                           BTN_INPUT,
    input  logic                           HALT,
    input  logic                           INPUT_WAIT,
    input  logic [PC_WIDTH-1:0]            PC,
    input  logic [NUM_BREAK*PC_WIDTH-1:0]  BREAK_ADDR,
    input  logic [NUM_BREAK-1:0]           BREAK_VALID,
    output logic                           CORE_EN,
    output logic [2:0]                     STATE,
    output logic [31:0]                    STEP_COUNT,
    output logic [NUM_BREAK-1:0]           BREAK_HIT
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_STEP       = 3'd1,
        ST_RUN        = 3'd2,
        ST_WAIT_INPUT = 3'd3,
        ST_HALTED     = 3'd4
    } state_t;

    state_t                 state_r;
    logic                   core_en_r;
    logic [31:0]            step_count_r;
    logic [NUM_BREAK-1:0]   break_hit_r;
    logic [DIV_W-1:0]       div_r;
    logic                   skip_r;
    logic                   ret_run_r;

    logic [2:0]             btn_raw_s;
    logic [2:0]             sync1_r;
    logic [2:0]             sync2_r;
    logic [2:0]             level_r;
    logic [2:0]             level_d_r;
    logic [CNT_W-1:0]       cnt_r [3];
    logic [2:0]             press_s;
    logic                   step_p_s;
    logic                   run_p_s;
    logic                   in_p_s;
    logic [NUM_BREAK-1:0]   bp_match_s;
    logic                   bp_stop_s;

    function automatic logic [DIV_W-1:0] div_inc(input logic [DIV_W-1:0] d);
        if (d == DIV_LAST) begin
            return DIV_ZERO;
        end else begin
            return d + DIV_W'(1);
        end
    endfunction

    assign btn_raw_s = {BTN_INPUT, BTN_RUN, BTN_STEP};
    assign press_s   = level_r & ~level_d_r;
    assign step_p_s  = press_s[0];
    assign run_p_s   = press_s[1];
    assign in_p_s    = press_s[2];

    // Synchronize and debounce each button; a level change needs an unbroken run of mismatching samples.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1_r   <= 3'b000;
            sync2_r   <= 3'b000;
            level_r   <= 3'b000;
            level_d_r <= 3'b000;
            for (int b = 0; b < 3; b++) begin
                cnt_r[b] <= '0;
            end
        end else begin
            sync1_r   <= btn_raw_s;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            for (int b = 0; b < 3; b++) begin
                if (sync2_r[b] == level_r[b]) begin
                    cnt_r[b] <= '0;
                end else if (cnt_r[b] == CNT_LAST) begin
                    cnt_r[b]   <= '0;
                    level_r[b] <= sync2_r[b];
                end else begin
                    cnt_r[b] <= cnt_r[b] + CNT_W'(1);
                end
            end
        end
    end

`ifdef EXEC_BREAKPOINT_EN
    // Per-comparator PC match against enabled breakpoint slices.
    always_comb begin
        bp_match_s = '0;
        for (int i = 0; i < NUM_BREAK; i++) begin
            bp_match_s[i] = BREAK_VALID[i] && (PC == BREAK_ADDR[i*PC_WIDTH +: PC_WIDTH]);
        end
    end
`else
    logic unused_bp_s;
    assign unused_bp_s = ^{PC, BREAK_ADDR, BREAK_VALID};
    assign bp_match_s  = '0;
`endif

    // The first issue after leaving IDLE ignores breakpoints so a run can resume from a breakpoint PC.
    assign bp_stop_s = (|bp_match_s) && !skip_r;

    // Execution FSM with registered CORE_EN, step counter and breakpoint flags.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            core_en_r    <= 1'b0;
            step_count_r <= 32'd0;
            break_hit_r  <= '0;
            div_r        <= DIV_ZERO;
            skip_r       <= 1'b0;
            ret_run_r    <= 1'b0;
        end else begin
            core_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (step_p_s) begin
                        state_r     <= ST_STEP;
                        skip_r      <= 1'b1;
                        break_hit_r <= '0;
                    end else if (run_p_s) begin
                        state_r     <= ST_RUN;
                        div_r       <= DIV_ZERO;
                        skip_r      <= 1'b1;
                        break_hit_r <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (HALT) begin
                        state_r <= ST_HALTED;
                    end else if (INPUT_WAIT) begin
                        ret_run_r <= 1'b0;
                        state_r   <= ST_WAIT_INPUT;
                    end else begin
                        core_en_r    <= 1'b1;
                        step_count_r <= step_count_r + 32'd1;
                        skip_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    div_r <= div_inc(div_r);
                    if (run_p_s) begin
                        state_r <= ST_IDLE;
                    end else if (div_r == DIV_ZERO) begin
                        if (HALT) begin
                            state_r <= ST_HALTED;
                        end else if (bp_stop_s) begin
                            break_hit_r <= break_hit_r | bp_match_s;
                            state_r     <= ST_IDLE;
                        end else if (INPUT_WAIT) begin
                            ret_run_r <= 1'b1;
                            state_r   <= ST_WAIT_INPUT;
                        end else begin
                            core_en_r    <= 1'b1;
                            step_count_r <= step_count_r + 32'd1;
                            skip_r       <= 1'b0;
                            state_r      <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_WAIT_INPUT: begin
                    if (run_p_s) begin
                        state_r <= ST_IDLE;
                    end else if (in_p_s) begin
                        if (HALT) begin
                            state_r <= ST_HALTED;
                        end else begin
                            core_en_r    <= 1'b1;
                            step_count_r <= step_count_r + 32'd1;
                            skip_r       <= 1'b0;
                            div_r        <= div_inc(DIV_ZERO);
                            state_r      <= ret_run_r ? ST_RUN : ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_WAIT_INPUT;
                    end
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign CORE_EN    = core_en_r;
    assign STATE      = state_r;
    assign STEP_COUNT = step_count_r;
    assign BREAK_HIT  = break_hit_r;

endmodule

// File: tb/tb_exec_step_control.sv
// Directed self-checking bench for exec_step_control (DEBOUNCE_CYCLES=4, RUN_DIV=3, NUM_BREAK=2).
module tb_exec_step_control;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        BTN_STEP;
    logic        BTN_RUN;
    logic        BTN_INPUT;
    logic        HALT;
    logic        INPUT_WAIT;
    logic [31:0] PC;
    logic [63:0] BREAK_ADDR;
    logic [1:0]  BREAK_VALID;
    logic        CORE_EN;
    logic [2:0]  STATE;
    logic [31:0] STEP_COUNT;
    logic [1:0]  BREAK_HIT;

    int checks = 0;
    int errors = 0;
    int pulses;
    int first_idx;
    int last_idx;

    exec_step_control #(
        .PC_WIDTH(32), .NUM_BREAK(2), .DEBOUNCE_CYCLES(4), .RUN_DIV(3)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .BTN_STEP(BTN_STEP), .BTN_RUN(BTN_RUN),
        .BTN_INPUT(BTN_INPUT), .HALT(HALT), .INPUT_WAIT(INPUT_WAIT), .PC(PC),
        .BREAK_ADDR(BREAK_ADDR), .BREAK_VALID(BREAK_VALID), .CORE_EN(CORE_EN),
        .STATE(STATE), .STEP_COUNT(STEP_COUNT), .BREAK_HIT(BREAK_HIT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        pulses    = 0;
        first_idx = -1;
        last_idx  = -1;
    endtask

    task automatic cycle(input int idx);
        @(posedge CLOCK);
        @(negedge CLOCK);
        if (CORE_EN === 1'b1) begin
            pulses++;
            if (first_idx < 0) first_idx = idx;
            last_idx = idx;
        end
    endtask

    // Drive buttons in mask {input,run,step} for hold cycles within a window of total cycles.
    task automatic press(input logic [2:0] mask, input int hold, input int total,
                         input int pc_at, input logic [31:0] pc_val);
        clear_mon();
        {BTN_INPUT, BTN_RUN, BTN_STEP} = mask;
        for (int i = 0; i < total; i++) begin
            cycle(i);
            if (i == pc_at) PC = pc_val;
            if (i == hold - 1) {BTN_INPUT, BTN_RUN, BTN_STEP} = 3'b000;
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; BTN_STEP = 1'b0; BTN_RUN = 1'b0; BTN_INPUT = 1'b0;
        HALT = 1'b0; INPUT_WAIT = 1'b0; PC = 32'h0;
        BREAK_ADDR = {32'h0, 32'h10}; BREAK_VALID = 2'b01;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        check("rst_core_en", {31'd0, CORE_EN}, 32'd0);
        check("rst_state", {29'd0, STATE}, 32'd0);
        check("rst_count", STEP_COUNT, 32'd0);
        check("rst_break_hit", {30'd0, BREAK_HIT}, 32'd0);

        // 1: held step button gives exactly one pulse, 8 cycles after the edge
        press(3'b001, 20, 20, -1, 32'h0);
        check("t1_pulses", pulses, 32'd1);
        check("t1_pulse_idx", first_idx, 32'd7);
        check("t1_count", STEP_COUNT, 32'd1);
        check("t1_state", {29'd0, STATE}, 32'd0);

        // 2: bouncing step button never settles long enough
        do_reset();
        clear_mon();
        for (int i = 0; i < 30; i++) begin
            BTN_STEP = ((i / 2) % 2) == 0;
            cycle(i);
        end
        BTN_STEP = 1'b0;
        for (int i = 30; i < 40; i++) cycle(i);
        check("t2_pulses", pulses, 32'd0);
        check("t2_count", STEP_COUNT, 32'd0);

        // 3: run for a while, then stop; pulses every third cycle
        do_reset();
        press(3'b010, 8, 30, -1, 32'h0);
        check("t3_run_pulses", pulses, 32'd8);
        check("t3_first_idx", first_idx, 32'd7);
        check("t3_last_idx", last_idx, 32'd28);
        check("t3_run_state", {29'd0, STATE}, 32'd2);
        press(3'b010, 8, 30, -1, 32'h0);
        check("t3_stop_pulses", pulses, 32'd2);
        check("t3_stop_last_idx", last_idx, 32'd4);
        check("t3_count", STEP_COUNT, 32'd10);
        check("t3_state", {29'd0, STATE}, 32'd0);

        // 4: breakpoint on PC 0x10 reached after two run pulses
        do_reset();
        PC = 32'h0;
        press(3'b010, 8, 14, 10, 32'h10);
`ifdef EXEC_BREAKPOINT_EN
        check("t4_pulses", pulses, 32'd2);
        check("t4_state", {29'd0, STATE}, 32'd0);
        check("t4_break_hit", {30'd0, BREAK_HIT}, 32'd1);
        check("t4_count", STEP_COUNT, 32'd2);
`else
        check("t4_pulses", pulses, 32'd3);
        check("t4_state", {29'd0, STATE}, 32'd2);
        check("t4_break_hit", {30'd0, BREAK_HIT}, 32'd0);
        check("t4_count", STEP_COUNT, 32'd3);
        do_reset();
`endif
        press(3'b001, 8, 16, -1, 32'h10);
        check("t4_step_pulses", pulses, 32'd1);
        check("t4_step_break_hit", {30'd0, BREAK_HIT}, 32'd0);
        check("t4_step_state", {29'd0, STATE}, 32'd0);
        PC = 32'h0;

        // Simultaneous step and run presses in IDLE: step wins
        do_reset();
        press(3'b011, 8, 16, -1, 32'h0);
        check("both_pulses", pulses, 32'd1);
        check("both_idx", first_idx, 32'd7);
        check("both_state", {29'd0, STATE}, 32'd0);

        // 5: input wait while running, input press resumes run
        do_reset();
        INPUT_WAIT = 1'b1;
        press(3'b010, 8, 16, -1, 32'h0);
        check("t5_enter_pulses", pulses, 32'd0);
        check("t5_enter_state", {29'd0, STATE}, 32'd3);
        clear_mon();
        for (int i = 0; i < 25; i++) cycle(i);
        INPUT_WAIT = 1'b0;
        for (int i = 25; i < 50; i++) cycle(i);
        check("t5_wait_pulses", pulses, 32'd0);
        check("t5_wait_state", {29'd0, STATE}, 32'd3);
        press(3'b100, 8, 8, -1, 32'h0);
        check("t5_in_pulses", pulses, 32'd1);
        check("t5_in_idx", first_idx, 32'd6);
        check("t5_in_state", {29'd0, STATE}, 32'd2);
        check("t5_count", STEP_COUNT, 32'd1);

        // 6: halt during run, buttons ignored, reset exits
        HALT = 1'b1;
        clear_mon();
        for (int i = 0; i < 4; i++) cycle(i);
        check("t6_halt_pulses", pulses, 32'd0);
        check("t6_halt_state", {29'd0, STATE}, 32'd4);
        press(3'b001, 8, 16, -1, 32'h0);
        check("t6_step_pulses", pulses, 32'd0);
        press(3'b010, 8, 16, -1, 32'h0);
        check("t6_run_pulses", pulses, 32'd0);
        check("t6_still_halted", {29'd0, STATE}, 32'd4);
        check("t6_count_kept", STEP_COUNT, 32'd1);
        do_reset();
        HALT = 1'b0;
        check("t6_rst_state", {29'd0, STATE}, 32'd0);
        check("t6_rst_count", STEP_COUNT, 32'd0);
        check("t6_rst_core_en", {31'd0, CORE_EN}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
